udp_tx_scheduler: RTL and testbench

Sequences the GMII UDP frame transmitter and shares it among NUM_REQ payload producers. Round-robin arbitration, length validation and UDP/IP length derivation. Presents one start pulse per frame to the transmitter, then enforces an inter-frame gap. Sits between the producers' payload RAMs and the UDP/IP transmitter, and steers the transmitter's RAM read port to the granted producer.

---
 rtl/udp_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 28 ++
 rtl/udp_tx_scheduler.sv | 139 +++++++++++++
 tb/tb_udp_tx_scheduler.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/udp_pkg.sv
// udp_pkg: shared state encoding, header sizes and payload limits for the UDP transmit scheduler
package udp_pkg;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CHECK = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;
    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        CHECK = ST_CHECK,
        START = ST_START,
        WAIT  = ST_WAIT,
        GAP   = ST_GAP
    } state_t;
    localparam int UDP_HDR_BYTES   = 8;
    localparam int IPV4_HDR_BYTES  = 20;
    localparam int DEF_MIN_PAYLOAD = 18;
    localparam int DEF_MAX_PAYLOAD = 1472;
    function automatic logic [2:0] wrap_inc(input logic [2:0] v, input int n);
        return (int'(v) == n - 1) ? 3'd0 : v + 3'd1;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, first set request at or after ptr, wrapping
//   req  in  NUM_REQ  request levels
//   ptr  in  3        highest-priority index
//   gnt  out NUM_REQ  one-hot grant (zero when no request)
//   idx  out 3        binary index of the grant
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [2:0]         idx
);
    // Scan offsets from farthest to nearest so the nearest set request wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (req[j] && j == (int'(ptr) + i) % NUM_REQ) begin
                    gnt    = '0;
                    gnt[j] = 1'b1;
                    idx    = 3'(j);
                end
            end
        end
    end
endmodule

// File: rtl/udp_tx_scheduler.sv
// udp_tx_scheduler: shares one UDP/IP frame transmitter among NUM_REQ producers
//   clk, rst           clock, async active-high reset
//   req, req_len       per-producer request level and 16-bit payload length slices
//   ack, err           one-cycle consume pulse, with err on bad length or timeout
//   sel                granted producer, steers the payload RAM mux
//   tx_start, tx_done  frame start pulse to and completion pulse from the transmitter
//   tx_data_length     UDP length, tx_total_length IP total length
//   busy               high whenever not idle
module udp_tx_scheduler
    import udp_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int IFG_CYCLES     = 12,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int MIN_PAYLOAD    = DEF_MIN_PAYLOAD,
    parameter int MAX_PAYLOAD    = DEF_MAX_PAYLOAD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [16*NUM_REQ-1:0] req_len,
    output logic [NUM_REQ-1:0]    ack,
    output logic [NUM_REQ-1:0]    err,
    output logic [2:0]            sel,
    output logic                  tx_start,
    output logic [15:0]           tx_data_length,
    output logic [15:0]           tx_total_length,
    input  logic                  tx_done,
    output logic                  busy
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(IFG_CYCLES + 1);

    state_t               state_q, state_d;
    logic [2:0]           sel_q, sel_d, ptr_q, ptr_d, gnt_idx;
    logic [15:0]          len_q, len_d, dlen_q, dlen_d, tlen_q, tlen_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d, err_q, err_d, gnt, sel_oh;
    logic                 tx_start_q, tx_start_d, busy_q, busy_d;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req (req),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    assign sel_oh = NUM_REQ'(1) << sel_q;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        len_d      = len_q;
        dlen_d     = dlen_q;
        tlen_d     = tlen_q;
        tmo_d      = tmo_q;
        gap_d      = gap_q;
        ack_d      = '0;
        err_d      = '0;
        tx_start_d = 1'b0;
        case (state_q)
            IDLE: if (|req) begin
                sel_d   = gnt_idx;
                for (int k = 0; k < NUM_REQ; k++)
                    if (gnt[k]) len_d = req_len[16*k +: 16];
                state_d = CHECK;
            end
            CHECK: if (len_q < 16'(MIN_PAYLOAD) || len_q > 16'(MAX_PAYLOAD)) begin
                ack_d   = sel_oh;
                err_d   = sel_oh;
                ptr_d   = wrap_inc(sel_q, NUM_REQ);
                state_d = IDLE;
            end else begin
                dlen_d  = len_q + 16'(UDP_HDR_BYTES);
                tlen_d  = len_q + 16'(UDP_HDR_BYTES + IPV4_HDR_BYTES);
                state_d = START;
            end
            START: begin
                tx_start_d = 1'b1;
                tmo_d      = '0;
                state_d    = WAIT;
            end
            // A done arriving on the terminal count still counts as success.
            WAIT: if (tx_done || tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                ack_d   = sel_oh;
                err_d   = tx_done ? '0 : sel_oh;
                ptr_d   = wrap_inc(sel_q, NUM_REQ);
                gap_d   = '0;
                state_d = GAP;
            end else begin
                tmo_d   = tmo_q + TW'(1);
            end
            GAP: if (gap_q == GW'(IFG_CYCLES - 1)) state_d = IDLE;
                 else gap_d = gap_q + GW'(1);
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            ptr_q      <= '0;
            len_q      <= '0;
            dlen_q     <= '0;
            tlen_q     <= '0;
            tmo_q      <= '0;
            gap_q      <= '0;
            ack_q      <= '0;
            err_q      <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            ptr_q      <= ptr_d;
            len_q      <= len_d;
            dlen_q     <= dlen_d;
            tlen_q     <= tlen_d;
            tmo_q      <= tmo_d;
            gap_q      <= gap_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
        end
    end

    assign ack             = ack_q;
    assign err             = err_q;
    assign sel             = sel_q;
    assign tx_start        = tx_start_q;
    assign tx_data_length  = dlen_q;
    assign tx_total_length = tlen_q;
    assign busy            = busy_q;
endmodule

// File: tb/tb_udp_tx_scheduler.sv
// tb_udp_tx_scheduler: directed stimulus with a timeline model checked every cycle
module tb_udp_tx_scheduler;
    localparam int NR = 4, IFG = 12, TMO = 4096, MINP = 18, MAXP = 1472;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req;
    logic [16*NR-1:0]  req_len;
    logic [NR-1:0]     ack, err;
    logic [2:0]        sel;
    logic              tx_start, tx_done, busy;
    logic [15:0]       tx_data_length, tx_total_length;
    logic              xdone = 1'b0, spur = 1'b0;
    int                done_delay = -1, pend = -1;
    int                total = 0, passed = 0;

    assign tx_done = xdone | spur;
    always #5 clk = ~clk;

    udp_tx_scheduler #(.NUM_REQ(NR), .IFG_CYCLES(IFG), .TIMEOUT_CYCLES(TMO),
                       .MIN_PAYLOAD(MINP), .MAX_PAYLOAD(MAXP)) dut (
        .clk(clk), .rst(rst), .req(req), .req_len(req_len), .ack(ack), .err(err),
        .sel(sel), .tx_start(tx_start), .tx_data_length(tx_data_length),
        .tx_total_length(tx_total_length), .tx_done(tx_done), .busy(busy)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    // Transmitter stand-in: answers tx_start with tx_done done_delay cycles later (never if negative).
    initial forever begin
        @(posedge clk); #1;
        xdone = 1'b0;
        if (tx_start) pend = done_delay;
        else if (pend > 0) begin
            pend--;
            if (pend == 0) xdone = 1'b1;
        end
    end

    // Timeline model: a frame granted in cycle g shows sel at g+1, lengths at g+2 (or ack+err
    // there if the length is illegal), tx_start at g+3; completion in cycle c gives ack at c+1
    // and idle again at c+IFG+1.
    int n = 0, g = 0, r = 0, c = 0, ptr_m = 0, k = 0;
    bit act = 0, vld = 0, dset = 0, to = 0, found = 0;
    logic [15:0]   len_m, e_dlen = '0, e_tlen = '0;
    logic [NR-1:0] e_ack, e_err;
    logic [2:0]    e_sel = '0;
    logic          e_start, e_busy;
    always @(negedge clk) begin
        n++;
        e_ack = '0;
        e_err = '0;
        e_start = 1'b0;
        if (rst) begin
            act = 0; ptr_m = 0; e_sel = '0; e_dlen = '0; e_tlen = '0;
        end else begin
            if (act) begin
                if (n == g + 1) e_sel = 3'(r);
                if (n == g + 2 && vld) begin e_dlen = len_m + 16'd8; e_tlen = len_m + 16'd28; end
                if (n == g + 2 && !vld) begin e_ack[r] = 1'b1; e_err[r] = 1'b1; ptr_m = (r + 1) % NR; act = 0; end
                if (n == g + 3 && vld) e_start = 1'b1;
                if (dset && n == c + 1) begin e_ack[r] = 1'b1; e_err[r] = to; ptr_m = (r + 1) % NR; end
                if (dset && n == c + IFG + 1) act = 0;
            end
            if (!act && req != '0) begin
                found = 0;
                for (int o = 0; o < NR; o++) begin
                    k = (ptr_m + o) % NR;
                    if (!found && req[k]) begin r = k; found = 1; end
                end
                g = n; act = 1; dset = 0; to = 0;
                len_m = req_len[16*r +: 16];
                vld = len_m >= MINP && len_m <= MAXP;
            end
        end
        e_busy = act && n > g;
        chk($sformatf("outputs cycle %0d {ack,err,sel,start,dlen,tlen,busy}", n),
            {ack, err, sel, tx_start, tx_data_length, tx_total_length, busy},
            {e_ack, e_err, e_sel, e_start, e_dlen, e_tlen, e_busy});
        if (!rst && act && vld && !dset && n >= g + 3) begin
            if (tx_done) begin c = n; dset = 1; end
            else if (n == g + 3 + TMO - 1) begin c = n; dset = 1; to = 1; end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_len(input int idx, input int l);
        req_len[16*idx +: 16] = 16'(l);
    endtask

    task automatic wait_start(input int max, output int t);
        t = 0;
        do begin tick(); t++; end while (!tx_start && t < max);
    endtask

    task automatic wait_ack(input int max, output int t, output logic [NR-1:0] a,
                            output logic [NR-1:0] e, output bit s);
        t = 0; s = 0;
        do begin tick(); t++; if (tx_start) s = 1; end while (ack == '0 && t < max);
        a = ack; e = err;
    endtask

    task automatic wait_idle(input int max, output int t);
        t = 0;
        do begin tick(); t++; end while (busy && t < max);
    endtask

    task automatic reset_pulse();
        rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1);
    end

    initial begin
        int t;
        logic [NR-1:0] a, e;
        bit s;
        int order[5] = '{0, 1, 2, 3, 0};
        int lens[4]  = '{17, 18, 1472, 1473};
        int tl[4]    = '{0, 46, 1500, 0};
        bit good[4]  = '{0, 1, 1, 0};
        rst = 1'b1; req = '0; req_len = '0;
        repeat (3) tick();
        chk("reset busy", busy, 0);
        chk("reset ack", ack, 0);
        chk("reset sel", sel, 0);
        rst = 1'b0; tick();
        // single request
        set_len(1, 100); done_delay = 200; req = 4'b0010;
        wait_start(10, t);
        chk("single start latency", t, 3);
        chk("single sel", sel, 1);
        chk("single data length", tx_data_length, 108);
        chk("single total length", tx_total_length, 128);
        wait_ack(400, t, a, e, s);
        chk("single ack delay", t, 201);
        chk("single ack", a, 4'b0010);
        chk("single err", e, 0);
        req = '0;
        wait_idle(50, t);
        chk("single gap", t, 12);
        // round robin from a fresh pointer
        reset_pulse();
        for (int i = 0; i < NR; i++) set_len(i, 64);
        done_delay = 50; req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_start(200, t);
            chk($sformatf("rr spacing %0d", i), t, i == 0 ? 3 : 66);
            chk($sformatf("rr sel %0d", i), sel, 3'(order[i]));
        end
        wait_ack(100, t, a, e, s);
        chk("rr last ack", a, 4'b0001);
        req = '0;
        wait_idle(50, t);
        // length bounds
        done_delay = 20;
        for (int i = 0; i < 4; i++) begin
            set_len(0, lens[i]); req = 4'b0001;
            if (!good[i]) begin
                wait_ack(10, t, a, e, s);
                chk($sformatf("len %0d reject delay", lens[i]), t, 2);
                chk($sformatf("len %0d ack", lens[i]), a, 4'b0001);
                chk($sformatf("len %0d err", lens[i]), e, 4'b0001);
                chk($sformatf("len %0d no start", lens[i]), s, 0);
                req = '0; tick();
            end else begin
                wait_start(10, t);
                chk($sformatf("len %0d start latency", lens[i]), t, 3);
                chk($sformatf("len %0d total length", lens[i]), tx_total_length, 16'(tl[i]));
                wait_ack(100, t, a, e, s);
                chk($sformatf("len %0d err", lens[i]), e, 0);
                req = '0;
                wait_idle(50, t);
                chk($sformatf("len %0d gap", lens[i]), t, 12);
            end
        end
        // timeout, then the next requester with done on the terminal count
        set_len(2, 64); set_len(3, 64); done_delay = -1; req = 4'b1100;
        wait_start(10, t);
        chk("timeout sel", sel, 2);
        wait_ack(5000, t, a, e, s);
        chk("timeout ack delay", t, 4096);
        chk("timeout ack", a, 4'b0100);
        chk("timeout err", e, 4'b0100);
        req = 4'b1000; done_delay = 4095;
        wait_start(50, t);
        chk("after timeout start", t, 15);
        chk("after timeout sel", sel, 3);
        wait_ack(5000, t, a, e, s);
        chk("terminal done ack delay", t, 4096);
        chk("terminal done ack", a, 4'b1000);
        chk("terminal done err", e, 0);
        req = '0;
        wait_idle(50, t);
        // reset mid-frame
        set_len(1, 100); done_delay = -1; req = 4'b0010;
        wait_start(10, t);
        repeat (10) tick();
        rst = 1'b1; #1;
        chk("async reset busy", busy, 0);
        chk("async reset sel", sel, 0);
        chk("async reset lengths", {tx_data_length, tx_total_length}, 0);
        chk("async reset start/ack/err", {tx_start, ack, err}, 0);
        req = '0;
        @(posedge clk); #1;
        rst = 1'b0; tick();
        spur = 1'b1; tick(); spur = 1'b0; tick();
        chk("stray done in idle busy", busy, 0);
        chk("stray done in idle ack", ack, 0);
        set_len(3, 64); done_delay = 30; req = 4'b1000;
        wait_start(10, t);
        chk("post reset start latency", t, 3);
        chk("post reset sel", sel, 3);
        wait_ack(100, t, a, e, s);
        chk("post reset ack delay", t, 31);
        chk("post reset ack", a, 4'b1000);
        req = '0;
        tick(); spur = 1'b1; tick(); spur = 1'b0;
        wait_idle(50, t);
        chk("stray done in gap", t, 10);
        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
